// File: rtl/timer_pkg.sv
// Shared types and constants for the maze-round countdown timer.
// Pure declarations; no logic, no latency, no flow control.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } t_timer_state;

  localparam int SECS_PER_MIN = 60;

endpackage

// File: rtl/sec_to_mmss.sv
// Splits a seconds count into minutes and seconds-within-minute for the HUD digits.
// Purely combinational (zero latency); no handshake, so there is nothing to stall.
module sec_to_mmss
  import timer_pkg::*;
#(
  parameter int TIME_WIDTH = 10
) (
  input  logic [TIME_WIDTH-1:0] i_secs,
  output logic [TIME_WIDTH-1:0] o_minutes,
  output logic [5:0]            o_seconds
);

  localparam logic [TIME_WIDTH-1:0] MIN_DIV = TIME_WIDTH'(SECS_PER_MIN);

  logic [TIME_WIDTH-1:0] w_rem;

  assign o_minutes = i_secs / MIN_DIV;
  assign w_rem     = i_secs % MIN_DIV;
  assign o_seconds = w_rem[5:0];

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Game countdown timer: prescaled 1 s decrement, pause/resume/abort, bonus add, auto-reload, warning.
// Registered state with one-cycle command response; tick/done are single-cycle pulses; no backpressure.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int COUNTS_PER_SEC  = 100_000_000,
  parameter int TIME_WIDTH      = 10,
  parameter int DEFAULT_SECONDS = 60,
  parameter int WARN_SECONDS    = 10
) (
  input  logic                  clk_100mhz_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  input  logic                  pause_in,
  input  logic                  resume_in,
  input  logic                  abort_in,
  input  logic                  auto_reload_in,
  input  logic                  load_valid_in,
  input  logic [TIME_WIDTH-1:0] load_seconds_in,
  input  logic                  add_valid_in,
  input  logic [TIME_WIDTH-1:0] add_seconds_in,
  output logic [TIME_WIDTH-1:0] time_out,
  output logic [TIME_WIDTH-1:0] minutes_out,
  output logic [5:0]            seconds_out,
  output logic                  tick_out,
  output logic                  warning_out,
  output logic                  running_out,
  output logic                  paused_out,
  output logic                  timer_done_out
);

  localparam int PW = $clog2(COUNTS_PER_SEC);
  localparam logic [PW-1:0]         PRESC_LAST = PW'(COUNTS_PER_SEC - 1);
  localparam logic [TIME_WIDTH-1:0] TIME_RST   = TIME_WIDTH'(DEFAULT_SECONDS);
  localparam logic [TIME_WIDTH-1:0] TIME_WARN  = TIME_WIDTH'(WARN_SECONDS);

  t_timer_state          r_state;
  logic [TIME_WIDTH-1:0] r_time;
  logic [TIME_WIDTH-1:0] r_reload;
  logic [PW-1:0]         r_presc;
  logic                  r_tick;
  logic                  r_done;

  t_timer_state          w_state_nxt;
  logic [TIME_WIDTH-1:0] w_time_nxt;
  logic [TIME_WIDTH-1:0] w_reload_nxt;
  logic [PW-1:0]         w_presc_nxt;
  logic                  w_tick_nxt;
  logic                  w_done_nxt;

  logic                  w_last;
  logic                  w_dec;
  logic [TIME_WIDTH-1:0] w_add;
  logic [TIME_WIDTH:0]   w_sum;
  logic [TIME_WIDTH-1:0] w_sat;

  assign w_last = (r_presc == PRESC_LAST);
  assign w_dec  = (r_state == RUNNING) && w_last;
  assign w_add  = add_valid_in ? add_seconds_in : '0;

  // r_time is never 0 while RUNNING, so the decrement cannot wrap below zero.
  assign w_sum = {1'b0, r_time} - {{TIME_WIDTH{1'b0}}, w_dec} + {1'b0, w_add};
  assign w_sat = w_sum[TIME_WIDTH] ? '1 : w_sum[TIME_WIDTH-1:0];

  always_ff @(posedge clk_100mhz_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= IDLE;
      r_time   <= TIME_RST;
      r_reload <= TIME_RST;
      r_presc  <= '0;
      r_tick   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_time   <= w_time_nxt;
      r_reload <= w_reload_nxt;
      r_presc  <= w_presc_nxt;
      r_tick   <= w_tick_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_time_nxt   = r_time;
    w_reload_nxt = r_reload;
    w_presc_nxt  = r_presc;
    w_tick_nxt   = 1'b0;
    w_done_nxt   = 1'b0;

    if (abort_in) begin
      w_state_nxt = IDLE;
      w_time_nxt  = r_reload;
      w_presc_nxt = '0;
    end else if (start_in) begin
      w_presc_nxt = '0;
      if (r_reload == '0) begin
        w_state_nxt = EXPIRED;
        w_time_nxt  = '0;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = RUNNING;
        w_time_nxt  = r_reload;
      end
    end else begin
      case (r_state)
        RUNNING: begin
          if (pause_in) begin
            w_state_nxt = PAUSED;
          end else if (w_last) begin
            w_presc_nxt = '0;
            w_tick_nxt  = 1'b1;
            // A bonus landing on the expiry edge keeps the round alive.
            if (w_sat == '0) begin
              w_done_nxt = 1'b1;
              if (auto_reload_in && (r_reload != '0)) begin
                w_time_nxt = r_reload;
              end else begin
                w_time_nxt  = '0;
                w_state_nxt = EXPIRED;
              end
            end else begin
              w_time_nxt = w_sat;
            end
          end else begin
            w_presc_nxt = r_presc + 1'b1;
            w_time_nxt  = w_sat;
          end
        end
        PAUSED: begin
          if (resume_in) begin
            w_state_nxt = RUNNING;
          end else begin
            w_time_nxt = w_sat;
          end
        end
        default: ;
      endcase
    end

    if (load_valid_in) begin
      w_reload_nxt = load_seconds_in;
      if ((r_state == IDLE) && !abort_in && !start_in) begin
        w_time_nxt = load_seconds_in;
      end
    end
  end

  always_comb begin
    running_out = (r_state == RUNNING);
    paused_out  = (r_state == PAUSED);
    warning_out = (running_out || paused_out) && (r_time != '0) && (r_time <= TIME_WARN);
  end

  assign time_out       = r_time;
  assign tick_out       = r_tick;
  assign timer_done_out = r_done;

  sec_to_mmss #(
    .TIME_WIDTH(TIME_WIDTH)
  ) u_mmss (
    .i_secs    (r_time),
    .o_minutes (minutes_out),
    .o_seconds (seconds_out)
  );

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with a 10-cycle second.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_countdown_timer_ctrl;

  localparam int TW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, pause, resume, abort, auto_rl;
  logic          load_vld, add_vld;
  logic [TW-1:0] load_secs, add_secs;
  logic [TW-1:0] t_out, min_out;
  logic [5:0]    sec_out;
  logic          tick, warn, run, paus, done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  countdown_timer_ctrl #(
    .COUNTS_PER_SEC  (10),
    .TIME_WIDTH      (TW),
    .DEFAULT_SECONDS (60),
    .WARN_SECONDS    (10)
  ) dut (
    .clk_100mhz_in   (clk),
    .rst_n_in        (rst_n),
    .start_in        (start),
    .pause_in        (pause),
    .resume_in       (resume),
    .abort_in        (abort),
    .auto_reload_in  (auto_rl),
    .load_valid_in   (load_vld),
    .load_seconds_in (load_secs),
    .add_valid_in    (add_vld),
    .add_seconds_in  (add_secs),
    .time_out        (t_out),
    .minutes_out     (min_out),
    .seconds_out     (sec_out),
    .tick_out        (tick),
    .warning_out     (warn),
    .running_out     (run),
    .paused_out      (paus),
    .timer_done_out  (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_cmds();
    start = 0; pause = 0; resume = 0; abort = 0; load_vld = 0; add_vld = 0;
  endtask

  initial begin
    rst_n = 0; auto_rl = 0; load_secs = '0; add_secs = '0;
    clear_cmds();

    // Reset state
    #23;
    chk("rst_time", t_out, 60);
    chk("rst_min", min_out, 1);
    chk("rst_sec", sec_out, 0);
    chk("rst_run", run, 0);
    chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);
    chk("rst_warn", warn, 0);
    rst_n = 1;
    cyc(1);

    // Default 60 s: first tick exactly 10 cycles after start
    start = 1; cyc(1); clear_cmds();
    chk("s60_run", run, 1);
    chk("s60_time0", t_out, 60);
    cyc(9);
    chk("s60_notick9", tick, 0);
    chk("s60_time9", t_out, 60);
    cyc(1);
    chk("s60_tick10", tick, 1);
    chk("s60_time10", t_out, 59);
    chk("s60_min", min_out, 0);
    chk("s60_sec", sec_out, 59);
    cyc(1);
    chk("s60_tickoff", tick, 0);

    abort = 1; cyc(1); clear_cmds();
    chk("abort_run", run, 0);
    chk("abort_time", t_out, 60);

    // One-shot 3 s
    load_vld = 1; load_secs = 3; cyc(1); clear_cmds();
    chk("ld3_idle_time", t_out, 3);
    chk("ld3_idle_warn", warn, 0);
    start = 1; cyc(1); clear_cmds();
    chk("os_warn", warn, 1);
    cyc(10);
    chk("os_tick1", tick, 1);
    chk("os_t1", t_out, 2);
    cyc(10);
    chk("os_t2", t_out, 1);
    chk("os_nodone2", done, 0);
    cyc(10);
    chk("os_tick3", tick, 1);
    chk("os_done", done, 1);
    chk("os_t3", t_out, 0);
    chk("os_stopped", run, 0);
    cyc(1);
    chk("os_done_off", done, 0);
    chk("os_hold0", t_out, 0);
    chk("os_warn_exp", warn, 0);

    // Auto-reload 2 s; load in EXPIRED does not touch time_out
    load_vld = 1; load_secs = 2; cyc(1); clear_cmds();
    chk("ld2_exp_time", t_out, 0);
    auto_rl = 1;
    start = 1; cyc(1); clear_cmds();
    chk("ar_time0", t_out, 2);
    cyc(20);
    chk("ar_done", done, 1);
    chk("ar_tick", tick, 1);
    chk("ar_reload", t_out, 2);
    chk("ar_run", run, 1);
    cyc(1);
    chk("ar_done_off", done, 0);
    auto_rl = 0;
    abort = 1; cyc(1); clear_cmds();

    // Pause at prescaler=4 for 50 cycles
    load_vld = 1; load_secs = 60; cyc(1); clear_cmds();
    start = 1; cyc(1); clear_cmds();
    cyc(4);
    pause = 1; cyc(1); clear_cmds();
    chk("pz_paused", paus, 1);
    chk("pz_run", run, 0);
    cyc(50);
    chk("pz_frozen", t_out, 60);
    chk("pz_notick", tick, 0);
    resume = 1; cyc(1); clear_cmds();
    chk("rs_run", run, 1);
    cyc(5);
    chk("rs_notick5", tick, 0);
    cyc(1);
    chk("rs_tick6", tick, 1);
    chk("rs_time", t_out, 59);
    abort = 1; cyc(1); clear_cmds();

    // Saturating add from 1020
    load_vld = 1; load_secs = 1020; cyc(1); clear_cmds();
    start = 1; cyc(1); clear_cmds();
    chk("sat_start", t_out, 1020);
    add_vld = 1; add_secs = 10; cyc(1); clear_cmds();
    chk("sat_time", t_out, 1023);
    chk("sat_min", min_out, 17);
    chk("sat_sec", sec_out, 3);
    abort = 1; cyc(1); clear_cmds();

    // Add on the expiry edge cancels expiry
    load_vld = 1; load_secs = 1; cyc(1); clear_cmds();
    start = 1; cyc(1); clear_cmds();
    cyc(9);
    add_vld = 1; add_secs = 5; cyc(1); clear_cmds();
    chk("xadd_time", t_out, 5);
    chk("xadd_nodone", done, 0);
    chk("xadd_tick", tick, 1);
    chk("xadd_run", run, 1);
    chk("xadd_warn", warn, 1);

    // Asynchronous reset mid-count, checked before any clock edge
    cyc(3);
    #2 rst_n = 0;
    #1;
    chk("arst_time", t_out, 60);
    chk("arst_run", run, 0);
    chk("arst_tick", tick, 0);
    chk("arst_done", done, 0);
    #3 rst_n = 1;
    cyc(1);

    // Zero duration: start goes straight to expiry
    load_vld = 1; load_secs = 0; cyc(1); clear_cmds();
    start = 1; cyc(1); clear_cmds();
    chk("zero_done", done, 1);
    chk("zero_time", t_out, 0);
    chk("zero_run", run, 0);
    cyc(1);
    chk("zero_done_off", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
